// File: rtl/spi_slave.sv
// SPI mode-0 slave with synchronised SCLK/CS/MOSI, byte-wide rx/tx and a valid/ready receive handshake.
// Optional sticky overrun flag and port enabled by defining SPI_SLAVE_OVERRUN_EN.
module spi_slave #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       SCLK,
  input  logic       CS,
  input  logic       MOSI,
  output logic       MISO,
  input  logic [7:0] tx_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       busy,
  output logic       done
`ifdef SPI_SLAVE_OVERRUN_EN
  ,
  output logic       overrun
`endif
);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_r;
  logic [SYNC_STAGES-1:0] cs_sync_r;
  logic [SYNC_STAGES-1:0] mosi_sync_r;
  logic [SYNC_STAGES-1:0] fill_r;
  logic                   armed_r;
  logic                   armed_now_s;
  logic                   sclk_rise_s;
  logic                   sclk_fall_s;
  logic                   cs_rise_s;
  logic                   cs_fall_s;
  logic                   mosi_s;

  state_t     state_r, state_next_s;
  logic [2:0] bit_cnt_r, bit_cnt_next_s;
  logic [6:0] tx_shift_r, tx_shift_next_s;
  logic [6:0] rx_shift_r, rx_shift_next_s;
  logic       miso_r, miso_next_s;
  logic [7:0] rx_data_r, rx_data_next_s;
  logic       rx_valid_r, rx_valid_next_s;
  logic       busy_r, busy_next_s;
  logic       done_r, done_next_s;
  logic       byte_done_r, byte_done_next_s;
`ifdef SPI_SLAVE_OVERRUN_EN
  logic       overrun_r, overrun_next_s;
`endif

  // Synchroniser chains; stage 0 is nearest the pin. fill_r marks stages holding genuine pin samples.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync_r <= '0;
      cs_sync_r   <= '1;
      mosi_sync_r <= '0;
      fill_r      <= '0;
      armed_r     <= 1'b0;
    end else begin
      sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], SCLK};
      cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], CS};
      mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], MOSI};
      fill_r      <= {fill_r[SYNC_STAGES-2:0], 1'b1};
      armed_r     <= armed_now_s;
    end
  end

  // A CS fall only counts once CS has really been seen high since reset, so a reset mid-frame waits for a new frame.
  assign armed_now_s = armed_r | (fill_r[SYNC_STAGES-1] & cs_sync_r[SYNC_STAGES-1]);
  assign sclk_rise_s = sclk_sync_r[SYNC_STAGES-2] & ~sclk_sync_r[SYNC_STAGES-1];
  assign sclk_fall_s = ~sclk_sync_r[SYNC_STAGES-2] & sclk_sync_r[SYNC_STAGES-1];
  assign cs_rise_s   = cs_sync_r[SYNC_STAGES-2] & ~cs_sync_r[SYNC_STAGES-1];
  assign cs_fall_s   = ~cs_sync_r[SYNC_STAGES-2] & cs_sync_r[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync_r[SYNC_STAGES-1];

  // State, shift registers and all registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      bit_cnt_r   <= 3'd0;
      tx_shift_r  <= 7'h00;
      rx_shift_r  <= 7'h00;
      miso_r      <= 1'b0;
      rx_data_r   <= 8'h00;
      rx_valid_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      byte_done_r <= 1'b0;
`ifdef SPI_SLAVE_OVERRUN_EN
      overrun_r   <= 1'b0;
`endif
    end else begin
      state_r     <= state_next_s;
      bit_cnt_r   <= bit_cnt_next_s;
      tx_shift_r  <= tx_shift_next_s;
      rx_shift_r  <= rx_shift_next_s;
      miso_r      <= miso_next_s;
      rx_data_r   <= rx_data_next_s;
      rx_valid_r  <= rx_valid_next_s;
      busy_r      <= busy_next_s;
      done_r      <= done_next_s;
      byte_done_r <= byte_done_next_s;
`ifdef SPI_SLAVE_OVERRUN_EN
      overrun_r   <= overrun_next_s;
`endif
    end
  end

  // Next-state and datapath; tx_shift holds only the bits still to send after the one on MISO.
  always_comb begin
    state_next_s     = state_r;
    bit_cnt_next_s   = bit_cnt_r;
    tx_shift_next_s  = tx_shift_r;
    rx_shift_next_s  = rx_shift_r;
    miso_next_s      = miso_r;
    rx_data_next_s   = rx_data_r;
    byte_done_next_s = byte_done_r;
    done_next_s      = 1'b0;
`ifdef SPI_SLAVE_OVERRUN_EN
    overrun_next_s   = overrun_r;
`endif
    if (rx_valid_r && rx_ready) begin
      rx_valid_next_s = 1'b0;
    end else begin
      rx_valid_next_s = rx_valid_r;
    end

    case (state_r)
      IDLE: begin
        miso_next_s = 1'b0;
        if (cs_fall_s && armed_now_s) begin
          state_next_s     = ACTIVE;
          tx_shift_next_s  = tx_data[6:0];
          miso_next_s      = tx_data[7];
          bit_cnt_next_s   = 3'd0;
          rx_shift_next_s  = 7'h00;
          byte_done_next_s = 1'b0;
        end else begin
          bit_cnt_next_s = 3'd0;
        end
      end
      ACTIVE: begin
        if (cs_rise_s) begin
          // Any partial byte is dropped here; rx_data/rx_valid are left alone.
          state_next_s     = IDLE;
          bit_cnt_next_s   = 3'd0;
          miso_next_s      = 1'b0;
          byte_done_next_s = 1'b0;
        end else if (sclk_rise_s) begin
          rx_shift_next_s = {rx_shift_r[5:0], mosi_s};
          bit_cnt_next_s  = bit_cnt_r + 3'd1;
          if (bit_cnt_r == 3'd7) begin
            rx_data_next_s   = {rx_shift_r, mosi_s};
            rx_valid_next_s  = 1'b1;
            done_next_s      = 1'b1;
            byte_done_next_s = 1'b1;
`ifdef SPI_SLAVE_OVERRUN_EN
            if (rx_valid_r && !rx_ready) begin
              overrun_next_s = 1'b1;
            end else begin
              overrun_next_s = overrun_r;
            end
`endif
          end else begin
            byte_done_next_s = 1'b0;
          end
        end else if (sclk_fall_s) begin
          if (bit_cnt_r != 3'd0) begin
            miso_next_s     = tx_shift_r[6];
            tx_shift_next_s = {tx_shift_r[5:0], 1'b0};
          end else if (byte_done_r) begin
            miso_next_s      = tx_data[7];
            tx_shift_next_s  = tx_data[6:0];
            byte_done_next_s = 1'b0;
          end else begin
            miso_next_s = miso_r;
          end
        end else begin
          state_next_s = ACTIVE;
        end
      end
      default: begin
        state_next_s = IDLE;
        miso_next_s  = 1'b0;
      end
    endcase

    busy_next_s = (state_next_s == ACTIVE);
  end

  assign MISO     = miso_r;
  assign rx_data  = rx_data_r;
  assign rx_valid = rx_valid_r;
  assign busy     = busy_r;
  assign done     = done_r;
`ifdef SPI_SLAVE_OVERRUN_EN
  assign overrun  = overrun_r;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Randomised bench for spi_slave: a bit-banging mode-0 master plus a byte-level scoreboard model
// of rx_data / rx_valid / overrun, with directed literal checks for the key scenarios.
module tb_spi_slave;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       SCLK = 1'b0;
  logic       CS = 1'b1;
  logic       MOSI = 1'b0;
  logic       MISO;
  logic [7:0] tx_data = 8'h00;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b1;
  logic       busy;
  logic       done;
`ifdef SPI_SLAVE_OVERRUN_EN
  logic       overrun;
`endif

  spi_slave #(.SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n), .SCLK(SCLK), .CS(CS), .MOSI(MOSI), .MISO(MISO),
    .tx_data(tx_data), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .busy(busy), .done(done)
`ifdef SPI_SLAVE_OVERRUN_EN
    , .overrun(overrun)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int half = 25;
  int ready_mode = 1;   // 0: hold 0, 1: hold 1, 2: random per cycle

  // Byte-level model: queue of bytes the master has sent, last delivered byte, pending-valid, sticky overrun.
  logic [7:0] exp_q[$];
  logic [7:0] m_data = 8'h00;
  logic       m_pend = 1'b0;
  logic       m_ovr = 1'b0;

  logic [7:0] fb[4];
  logic [7:0] ft[4];
  logic [7:0] got_a[4];
  int         fn;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // rx_ready changes just after a rising edge so the monitor sees the value the next edge will use.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: rx_ready = 1'b0;
        1: rx_ready = 1'b1;
        default: rx_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Compare process: every cycle, rx_valid/rx_data/overrun against the model; reset values while in reset.
  always @(negedge clk) begin
    logic ev;
    if (!reset_n) begin
      exp_q.delete();
      m_data = 8'h00;
      m_pend = 1'b0;
      m_ovr  = 1'b0;
      chk("rst_miso", MISO, 0);
      chk("rst_rx_data", rx_data, 0);
      chk("rst_rx_valid", rx_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
`ifdef SPI_SLAVE_OVERRUN_EN
      chk("rst_overrun", overrun, 0);
`endif
    end else begin
      ev = m_pend;
      if (done === 1'b1) begin
        done_cnt++;
        ev = 1'b1;
        if (m_pend) m_ovr = 1'b1;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_done: got done=1 expected no byte pending");
        end else begin
          m_data = exp_q.pop_front();
        end
      end
      chk("rx_valid", rx_valid, ev);
      chk("rx_data", rx_data, m_data);
`ifdef SPI_SLAVE_OVERRUN_EN
      chk("overrun", overrun, m_ovr);
`endif
      m_pend = ev & ~rx_ready;
    end
  end

  // Clock nbits of b out MSB first in mode 0; MISO is sampled just before each rising SCLK.
  task automatic xfer_bits(input logic [7:0] b, input int nbits, output logic [7:0] got);
    got = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      MOSI = b[i];
      wait_clk(half);
      got[i] = MISO;
      SCLK = 1'b1;
      wait_clk(half);
      SCLK = 1'b0;
    end
  endtask

  // One CS assertion carrying fn bytes fb[], with tx_data = ft[k] presented for byte k.
  task automatic frame();
    logic [7:0] g;
    tx_data = ft[0];
    CS = 1'b0;
    wait_clk(half);
    chk("busy_active", busy, 1);
    for (int k = 0; k < fn; k++) begin
      tx_data = ft[k];
      exp_q.push_back(fb[k]);
      xfer_bits(fb[k], 8, g);
      got_a[k] = g;
      chk("miso_byte", g, ft[k]);
    end
    wait_clk(half);
    CS = 1'b1;
    wait_clk(8);
    chk("busy_idle", busy, 0);
    chk("miso_idle", MISO, 0);
  endtask

  initial begin
    #900000;
    errors++;
    $display("FAIL timeout: got no finish expected finish before 900000");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int d0;
    logic [7:0] g;
    reset_n = 1'b0;
    wait_clk(3);
    chk("reset_miso", MISO, 0);
    chk("reset_rx_data", rx_data, 8'h00);
    chk("reset_busy", busy, 0);
    @(negedge clk); #1 reset_n = 1'b1;
    wait_clk(5);

    // Single byte at clk/50: master sends A5, slave returns 3C.
    half = 25; ready_mode = 1;
    d0 = done_cnt; fn = 1; fb[0] = 8'hA5; ft[0] = 8'h3C;
    frame();
    chk("t1_rx", rx_data, 8'hA5);
    chk("t1_miso", got_a[0], 8'h3C);
    chk("t1_done", done_cnt - d0, 1);

    // Back-to-back bytes in one frame with tx_data changed between them.
    d0 = done_cnt; fn = 2; fb[0] = 8'h12; fb[1] = 8'h34; ft[0] = 8'h55; ft[1] = 8'hAA;
    frame();
    chk("t2_rx", rx_data, 8'h34);
    chk("t2_miso0", got_a[0], 8'h55);
    chk("t2_miso1", got_a[1], 8'hAA);
    chk("t2_done", done_cnt - d0, 2);

    // Aborted byte: CS raised after 5 SCLK cycles, then a full F0.
    half = 10; d0 = done_cnt;
    tx_data = 8'h99; CS = 1'b0; wait_clk(half);
    xfer_bits(8'hFF, 5, g);
    wait_clk(half); CS = 1'b1; wait_clk(10);
    chk("t3_no_done", done_cnt - d0, 0);
    chk("t3_rx_keep", rx_data, 8'h34);
    chk("t3_valid", rx_valid, 0);
    chk("t3_miso", MISO, 0);
    fn = 1; fb[0] = 8'hF0; ft[0] = 8'h0F;
    frame();
    chk("t3_rx", rx_data, 8'hF0);

    // Consumer stalled across two bytes.
    ready_mode = 0; wait_clk(3);
    fn = 2; fb[0] = 8'h01; fb[1] = 8'h02; ft[0] = 8'hC0; ft[1] = 8'h3E;
    frame();
    chk("t4_rx", rx_data, 8'h02);
    chk("t4_valid", rx_valid, 1);
`ifdef SPI_SLAVE_OVERRUN_EN
    chk("t4_overrun", overrun, 1);
`endif
    ready_mode = 1; wait_clk(5);

    // Randomised frames, speeds and consumer back-pressure.
    ready_mode = 2;
    for (int f = 0; f < 25; f++) begin
      half = $urandom_range(5, 20);
      fn = $urandom_range(1, 3);
      for (int k = 0; k < 4; k++) begin
        fb[k] = 8'($urandom);
        ft[k] = 8'($urandom);
      end
      frame();
      wait_clk($urandom_range(0, 12));
    end
    ready_mode = 1; wait_clk(5);

    // Reset in the middle of bit 4; the slave must wait for a fresh CS fall.
    half = 10;
    tx_data = 8'h5A; CS = 1'b0; wait_clk(half);
    xfer_bits(8'hC3, 4, g);
    @(negedge clk); #1 reset_n = 1'b0;
    wait_clk(3);
    chk("t5_rx_data", rx_data, 8'h00);
    chk("t5_valid", rx_valid, 0);
    chk("t5_miso", MISO, 0);
    @(negedge clk); #1 reset_n = 1'b1;
    wait_clk(10);
    chk("t5_busy_after", busy, 0);
    chk("t5_miso_after", MISO, 0);
    CS = 1'b1; wait_clk(10);
    fn = 1; fb[0] = 8'h7E; ft[0] = 8'h81;
    frame();
    chk("t5_rx", rx_data, 8'h7E);
    chk("t5_miso_byte", got_a[0], 8'h81);

    wait_clk(5);
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
